// File: rtl/dup_range_pkg.sv
// Shared state encodings and helper functions for the repeating range generator.
package dup_range_pkg;

  localparam logic [1:0] StDone  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StEmit  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  // Widest supported WIDTH; callers sign-extend their operands to this size.
  localparam int unsigned ArgW  = 64;
  localparam int unsigned ArgW1 = ArgW + 1;

  // Effective repeat count: the requested count limited to the configured maximum.
  function automatic logic [31:0] clamp_repeat(input logic [31:0] rep,
                                               input logic [31:0] max_rep);
    return (rep > max_rep) ? max_rep : rep;
  endfunction

  // True when val is still inside range(.., limit, step); step == 0 is an empty range.
  function automatic logic range_cont(input logic signed [ArgW:0]   val,
                                      input logic signed [ArgW-1:0] limit,
                                      input logic signed [ArgW-1:0] step);
    logic signed [ArgW:0] lim_x;
    logic                 step_pos;
    logic                 step_neg;
    lim_x    = {limit[ArgW-1], limit};
    step_neg = step[ArgW-1];
    step_pos = !step[ArgW-1] && (|step);
    if (step_pos) begin
      return val < lim_x;
    end else if (step_neg) begin
      return val > lim_x;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/hrange_n.sv
// Single-pass range generator: emits range(base, limit, step) over ready/valid.
module hrange_n
  import dup_range_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0
);

  logic signed [WIDTH-1:0] cur_q, cur_d;
  logic signed [WIDTH-1:0] lim_q, lim_d;
  logic signed [WIDTH-1:0] step_q, step_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    pend_q, pend_d;
  logic signed [WIDTH:0]   nxt;
  logic                    cont_cur;
  logic                    cont_nxt;

  // Next value at WIDTH+1 bits so an overflow ends the range instead of wrapping.
  always_comb begin
    nxt      = {cur_q[WIDTH-1], cur_q} + {step_q[WIDTH-1], step_q};
    cont_cur = range_cont(ArgW1'(cur_q), ArgW'(lim_q), ArgW'(step_q));
    cont_nxt = range_cont(ArgW1'(nxt), ArgW'(lim_q), ArgW'(step_q));
  end

  // Capture arguments on start, test the first value one cycle later, then step per handshake.
  always_comb begin
    cur_d   = cur_q;
    lim_d   = lim_q;
    step_d  = step_q;
    valid_d = valid_q;
    done_d  = done_q;
    pend_d  = 1'b0;
    if (_start) begin
      cur_d   = base;
      lim_d   = limit;
      step_d  = step;
      valid_d = 1'b0;
      done_d  = 1'b0;
      pend_d  = 1'b1;
    end else if (pend_q) begin
      valid_d = cont_cur;
      done_d  = !cont_cur;
    end else if (valid_q && _ready) begin
      if (cont_nxt) begin
        cur_d = nxt[WIDTH-1:0];
      end else begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      cur_q   <= '0;
      lim_q   <= '0;
      step_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      lim_q   <= lim_d;
      step_q  <= step_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign _valid = valid_q;
  assign _done  = done_q;
  assign _0     = cur_q;

endmodule

// File: rtl/dup_range_n.sv
// Repeating range generator: every value of an inner range is emitted R times with its index.
module dup_range_n
  import dup_range_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MAX_REPEAT = 2,
  parameter int unsigned RW         = $clog2(MAX_REPEAT + 1)
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic [RW-1:0]           repeat_cnt,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0,
  output logic [RW-1:0]           _1
);

  logic [1:0]              state_q, state_d;
  logic signed [WIDTH-1:0] base_q, base_d, limit_q, limit_d, step_q, step_d;
  logic [RW-1:0]           r_q, r_d, idx_q, idx_d;
  logic signed [WIDTH-1:0] val_q, val_d, pf_val_q, pf_val_d;
  logic                    valid_q, valid_d, pf_full_q, pf_full_d;
  logic                    inner_start_q, inner_start_d;
  logic                    in_ready, in_valid, in_done;
  logic signed [WIDTH-1:0] in_val;
  logic                    inner_hs, in_done_m, out_hs, last, exhausted;

  hrange_n #(
    .WIDTH(WIDTH)
  ) u_hrange (
    ._clock(_clock),
    ._reset(_reset),
    ._start(inner_start_q),
    .base  (base_q),
    .limit (limit_q),
    .step  (step_q),
    ._ready(in_ready),
    ._valid(in_valid),
    ._done (in_done),
    ._0    (in_val)
  );

  // FSM, repeat counter and prefetch register. While the inner start pulse is in flight the
  // inner outputs still describe the previous generation, so they are masked.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    limit_d       = limit_q;
    step_d        = step_q;
    r_d           = r_q;
    idx_d         = idx_q;
    val_d         = val_q;
    valid_d       = valid_q;
    pf_val_d      = pf_val_q;
    pf_full_d     = pf_full_q;
    inner_start_d = 1'b0;
    exhausted     = 1'b0;
    case (state_q)
      StFetch: in_ready = !inner_start_q;
      StEmit:  in_ready = !inner_start_q && !pf_full_q;
      default: in_ready = 1'b0;
    endcase
    inner_hs  = in_valid && in_ready;
    in_done_m = in_done && !inner_start_q;
    out_hs    = valid_q && _ready;
    last      = out_hs && (idx_q == r_q - RW'(1));
    if (_start) begin
      base_d    = base;
      limit_d   = limit;
      step_d    = step;
      r_d       = RW'(clamp_repeat(32'(repeat_cnt), 32'(MAX_REPEAT)));
      idx_d     = '0;
      valid_d   = 1'b0;
      pf_full_d = 1'b0;
      if (r_d == '0) begin
        state_d = StDone;
      end else begin
        state_d       = StFetch;
        inner_start_d = 1'b1;
      end
    end else begin
      case (state_q)
        StFetch: begin
          if (inner_hs) begin
            val_d   = in_val;
            valid_d = 1'b1;
            idx_d   = '0;
            state_d = StEmit;
          end else if (in_done_m) begin
            state_d = StDone;
          end
        end
        StEmit, StDrain: begin
          if (inner_hs) begin
            pf_val_d  = in_val;
            pf_full_d = 1'b1;
          end
          if (state_q == StEmit && in_done_m) begin
            state_d = StDrain;
          end
          exhausted = (state_q == StDrain) || in_done_m;
          if (out_hs && !last) begin
            idx_d = idx_q + RW'(1);
          end else if (last || !valid_q) begin
            // Last copy taken (or stalled): move to the next value if one is available.
            idx_d = '0;
            if (pf_full_q) begin
              val_d     = pf_val_q;
              pf_full_d = 1'b0;
              valid_d   = 1'b1;
            end else if (inner_hs) begin
              val_d     = in_val;
              pf_full_d = 1'b0;
              valid_d   = 1'b1;
            end else if (exhausted) begin
              valid_d = 1'b0;
              state_d = StDone;
            end else begin
              valid_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q       <= StDone;
      base_q        <= '0;
      limit_q       <= '0;
      step_q        <= '0;
      r_q           <= '0;
      idx_q         <= '0;
      val_q         <= '0;
      valid_q       <= 1'b0;
      pf_val_q      <= '0;
      pf_full_q     <= 1'b0;
      inner_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      limit_q       <= limit_d;
      step_q        <= step_d;
      r_q           <= r_d;
      idx_q         <= idx_d;
      val_q         <= val_d;
      valid_q       <= valid_d;
      pf_val_q      <= pf_val_d;
      pf_full_q     <= pf_full_d;
      inner_start_q <= inner_start_d;
    end
  end

  assign _valid = valid_q;
  assign _done  = (state_q == StDone);
  assign _0     = val_q;
  assign _1     = idx_q;

endmodule

// File: tb/tb_dup_range_n.sv
// Directed bench for dup_range_n: two instances (MAX_REPEAT 2 and 4) share stimulus.
module tb_dup_range_n;

  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start2 = 1'b0, start4 = 1'b0;
  logic signed [W-1:0] base = '0, limit = '0, step = '0;
  logic [2:0]          rep = '0;
  logic                ready = 1'b0;
  logic                sel = 1'b0;
  logic                valid2, done2, valid4, done4;
  logic signed [W-1:0] o0_2, o0_4;
  logic [2:0]          o1_2, o1_4;
  logic                vm, dm;
  logic signed [W-1:0] o0m;
  logic [2:0]          o1m;

  dup_range_n #(.WIDTH(W), .MAX_REPEAT(2), .RW(3)) u_dut2 (
    ._clock(clk), ._reset(rst_n), ._start(start2), .base(base), .limit(limit), .step(step),
    .repeat_cnt(rep), ._ready(ready), ._valid(valid2), ._done(done2), ._0(o0_2), ._1(o1_2)
  );

  dup_range_n #(.WIDTH(W), .MAX_REPEAT(4), .RW(3)) u_dut4 (
    ._clock(clk), ._reset(rst_n), ._start(start4), .base(base), .limit(limit), .step(step),
    .repeat_cnt(rep), ._ready(ready), ._valid(valid4), ._done(done4), ._0(o0_4), ._1(o1_4)
  );

  always #5 clk = ~clk;

  assign vm  = sel ? valid4 : valid2;
  assign dm  = sel ? done4 : done2;
  assign o0m = sel ? o0_4 : o0_2;
  assign o1m = sel ? o1_4 : o1_2;

  typedef struct {int v; int k;} ent_t;
  ent_t got_q[$];
  ent_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   first_idx, done_idx, stall_err;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int v, input int k);
    exp_q.push_back('{v, k});
  endtask

  // Start on the edge following the next falling edge ("edge 0"); returns just after it.
  task automatic start_gen(input bit s, input int b, input int l, input int st, input int r);
    @(negedge clk);
    sel   = s;
    base  = b;
    limit = l;
    step  = st;
    rep   = r[2:0];
    if (s) start4 = 1'b1;
    else start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  // Sample index c is the falling edge after edge c.
  task automatic collect(input bit rnd, input int budget);
    logic pv, pr;
    logic signed [W-1:0] p0;
    logic [2:0] p1;
    got_q.delete();
    first_idx = -1;
    done_idx  = -1;
    stall_err = 0;
    pv = 1'b0;
    pr = 1'b1;
    p0 = '0;
    p1 = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (pv && !pr && !(vm && o0m == p0 && o1m == p1)) stall_err++;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vm && first_idx < 0) first_idx = c;
      if (vm && ready) got_q.push_back('{int'(o0m), int'(o1m)});
      if (dm) begin
        done_idx = c;
        break;
      end
      pv = vm;
      pr = ready;
      p0 = o0m;
      p1 = o1m;
    end
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, " count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s val[%0d]", tag, i), got_q[i].v, exp_q[i].v);
      check($sformatf("%s idx[%0d]", tag, i), got_q[i].k, exp_q[i].k);
    end
  endtask

  initial begin
    int acc, bad;
    #2;
    check("reset valid", vm, 0);
    check("reset done", dm, 1);
    check("reset _0", o0m, 0);
    check("reset _1", o1m, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // (0,10,2) x2
    exp_q.delete();
    push(0, 0); push(0, 1); push(2, 0); push(2, 1); push(4, 0);
    push(4, 1); push(6, 0); push(6, 1); push(8, 0); push(8, 1);
    start_gen(0, 0, 10, 2, 2);
    collect(0, 40);
    compare("t1");
    check("t1 first valid", first_idx, 3);
    check("t1 done edge", done_idx, 13);

    // (10,0,-3) x3 on MAX_REPEAT=4
    exp_q.delete();
    push(10, 0); push(10, 1); push(10, 2); push(7, 0); push(7, 1); push(7, 2);
    push(4, 0); push(4, 1); push(4, 2); push(1, 0); push(1, 1); push(1, 2);
    start_gen(1, 10, 0, -3, 3);
    collect(0, 40);
    compare("t2");
    check("t2 first valid", first_idx, 3);
    check("t2 done edge", done_idx, 15);

    // Empty ranges
    exp_q.delete();
    start_gen(0, 5, 5, 1, 2);
    collect(0, 20);
    compare("t3a");
    check("t3a done edge", done_idx, 3);
    start_gen(0, 0, 10, 0, 2);
    collect(0, 20);
    compare("t3b");
    check("t3b done edge", done_idx, 3);
    start_gen(0, 0, 10, 1, 0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (vm || !dm) bad++;
    end
    check("t3c repeat0 valid/done", bad, 0);

    // Clamp: repeat 7 on MAX_REPEAT=2
    exp_q.delete();
    push(0, 0); push(0, 1); push(1, 0); push(1, 1); push(2, 0); push(2, 1);
    start_gen(0, 0, 3, 1, 7);
    collect(0, 40);
    compare("t4");
    check("t4 done edge", done_idx, 9);

    // Random backpressure, (0,20,1) x2
    exp_q.delete();
    for (int v = 0; v < 20; v++) begin
      push(v, 0);
      push(v, 1);
    end
    start_gen(0, 0, 20, 1, 2);
    collect(1, 400);
    compare("t5");
    check("t5 stall stability", stall_err, 0);
    check("t5 done seen", done_idx >= 0, 1);

    // Restart after three outputs
    start_gen(0, 0, 10, 1, 2);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ready = 1'b1;
      if (vm && ready) acc++;
    end
    check("t6 outputs before restart", acc, 3);
    exp_q.delete();
    push(100, 0); push(100, 1); push(101, 0); push(101, 1); push(102, 0); push(102, 1);
    start_gen(0, 100, 103, 1, 2);
    collect(0, 40);
    compare("t6");
    check("t6 first valid", first_idx, 3);
    check("t6 done edge", done_idx, 9);

    // Reset during EMIT
    start_gen(0, 100, 103, 1, 2);
    ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t7 emitting before reset", vm, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7 reset valid", vm, 0);
    check("t7 reset done", dm, 1);
    check("t7 reset _0", o0m, 0);
    check("t7 reset _1", o1m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (vm || !dm) bad++;
    end
    check("t7 idle after reset", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
